// File: rtl/i2c_enc_arbiter.sv
// Round-robin arbiter sharing one I2C encoder-read engine and channel mux among NUM_REQ requesters.
// Optional build macro I2C_ARB_STATS_EN adds saturating per-requester error counters (err_cnt).
module i2c_enc_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   rd_done,
  output logic [NUM_REQ-1:0]   rd_err,
  output logic [11:0]          rd_data,
  output logic                 busy,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 i2c_start,
  input  logic                 i2c_done,
  input  logic                 i2c_nack,
  input  logic [11:0]          i2c_data
`ifdef I2C_ARB_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] err_cnt
`endif
);

  // state    | meaning
  // IDLE     | no transaction; grant next requester round-robin from rr_ptr
  // SETTLE   | mux_sel changed, waiting SETTLE_CYCLES for the channel to settle
  // START    | one-cycle i2c_start pulse, timeout window opens
  // WAIT     | waiting for i2c_done / i2c_nack / timeout
  // RESP_OK  | rd_done pulse to the granted requester
  // RESP_ERR | rd_err pulse to the granted requester
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT, S_RESP_OK, S_RESP_ERR
  } state_t;

  localparam int MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [11:0]      data_nxt;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] next_ptr;
  logic [NUM_REQ-1:0] gnt_oh;

  // Lowest set bit overall covers the wrap case; lowest set bit at/above rr_ptr overrides it.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick_vld = 1'b1;
        pick_idx = SEL_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (SEL_W'(j) >= rr_ptr)) pick_idx = SEL_W'(j);
    end
  end

  // mux_sel doubles as the registered grant index.
  assign next_ptr = (mux_sel == SEL_W'(NUM_REQ - 1)) ? '0 : mux_sel + SEL_W'(1);
  assign gnt_oh   = NUM_REQ'(1) << mux_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tmr     <= '0;
      rr_ptr  <= '0;
      mux_sel <= '0;
      rd_data <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      rr_ptr  <= rr_nxt;
      mux_sel <= sel_nxt;
      rd_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    rr_nxt    = rr_ptr;
    sel_nxt   = mux_sel;
    data_nxt  = rd_data;
    busy      = (state != S_IDLE);
    i2c_start = 1'b0;
    rd_done   = '0;
    rd_err    = '0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          sel_nxt   = pick_idx;
          tmr_nxt   = SETTLE_LOAD;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          tmr_nxt   = TIMEOUT_LOAD;
          state_nxt = S_START;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      // The timeout window includes the START clock, so the error lands TIMEOUT_CYCLES after i2c_start.
      S_START: begin
        i2c_start = 1'b1;
        tmr_nxt   = tmr - TMR_W'(1);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done && !i2c_nack) begin
          data_nxt  = i2c_data;
          state_nxt = S_RESP_OK;
        end else if (i2c_nack || (tmr == '0)) begin
          state_nxt = S_RESP_ERR;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      S_RESP_OK: begin
        rd_done   = gnt_oh;
        rr_nxt    = next_ptr;
        state_nxt = S_IDLE;
      end
      S_RESP_ERR: begin
        rd_err    = gnt_oh;
        rr_nxt    = next_ptr;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef I2C_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (state == S_RESP_ERR) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((mux_sel == SEL_W'(i)) && (err_cnt[i*8 +: 8] != 8'hFF))
          err_cnt[i*8 +: 8] <= err_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
